mips_cpu_store_unit: RTL and testbench

Store-side counterpart to the register file's partial-load merge. It takes a store request from the CPU core (opcode, byte address, rt value) and performs one word-addressed, byte-enabled write on an Avalon-MM-style data bus. It covers sb, sh, sw, swl and swr with little-endian lane mapping: byte offset k occupies bits [8k+7:8k] and byteenable[k]. It holds the write through waitrequest and reports completion or error back to the core's stall logic.

---
 rtl/mips_cpu_pkg.sv | 19 +
 rtl/mips_cpu_store_unit_if.sv | 32 +++
 rtl/mips_cpu_store_align.sv | 52 +++++
 rtl/mips_cpu_store_unit.sv | 139 +++++++++++++
 tb/tb_mips_cpu_store_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared opcodes, state encoding and small types for the MIPS store path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_cpu_pkg;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } store_state_t;

  typedef logic [1:0] byte_off_t;

endpackage

// File: rtl/mips_cpu_store_unit_if.sv
// Core request / completion signals plus the Avalon-MM style write bus.
// Latency: n/a (wiring only).
// Backpressure: req_ready toward the core, waitrequest from the bus.
// slave  : the store unit (accepts requests, masters the data bus)
// master : the core + memory side (issues requests, answers waitrequest)
interface mips_cpu_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        done;
  logic        bus_err;
  logic        addr_err;
  logic [31:0] address;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;

  modport slave (
    input  req_valid, req_opcode, req_addr, req_data, waitrequest,
    output req_ready, done, bus_err, addr_err,
    output address, write, byteenable, writedata
  );

  modport master (
    output req_valid, req_opcode, req_addr, req_data, waitrequest,
    input  req_ready, done, bus_err, addr_err,
    input  address, write, byteenable, writedata
  );
endinterface

// File: rtl/mips_cpu_store_align.sv
// Maps a store (opcode, byte offset, rt) onto little-endian lane enables and data.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: opcode/offset/rt in; byteenable, writedata, is_store, misaligned out.
module mips_cpu_store_align
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  byte_off_t   offset,
  input  logic [31:0] rt,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        is_store,
  output logic        misaligned
);

  always_comb begin
    byteenable = 4'b0000;
    writedata  = 32'h0;
    is_store   = 1'b1;
    misaligned = 1'b0;
    case (opcode)
      OP_SB: begin
        byteenable = 4'b0001 << offset;
        writedata  = {4{rt[7:0]}};
      end
      OP_SH: begin
        // Only offset[1] selects the half; offset[0] only matters for alignment.
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{rt[15:0]}};
        misaligned = offset[0];
      end
      OP_SW: begin
        byteenable = 4'b1111;
        writedata  = rt;
        misaligned = (offset != 2'd0);
      end
      OP_SWL: begin
        // Most significant bytes of rt land at and below the addressed lane.
        byteenable = 4'b1111 >> (2'd3 - offset);
        writedata  = rt >> {(2'd3 - offset), 3'b000};
      end
      OP_SWR: begin
        // Least significant bytes of rt land at and above the addressed lane.
        byteenable = 4'b1111 << offset;
        writedata  = rt << {offset, 3'b000};
      end
      default: is_store = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_store_unit.sv
// Issues one byte-enabled word write per core store request and reports done/errors.
// Latency: accept edge -> write high 1 cycle; done 1 cycle after the releasing edge (min 2 cycles/store).
// Backpressure: req_ready only in IDLE; write held stable while waitrequest, optional WAIT_LIMIT abort.
// Ports: clk, reset_n (async active-low), bus (mips_cpu_store_unit_if.slave).
// Optional feature macro: MIPS_STORE_ALIGN_CHECK_EN rejects misaligned sh/sw with addr_err.
module mips_cpu_store_unit
  import mips_cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
)
(
  input  logic                  clk,
  input  logic                  reset_n,
  mips_cpu_store_unit_if.slave  bus
);

  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  // Counter value at which one more stalled edge hits the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  store_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             write_q, write_nxt;
  logic [31:0]      addr_q, addr_nxt;
  logic [3:0]       be_q, be_nxt;
  logic [31:0]      data_q, data_nxt;
  logic             done_q, done_nxt;
  logic             bus_err_q, bus_err_nxt;
  logic             addr_err_q, addr_err_nxt;

  logic [3:0]       be_c;
  logic [31:0]      data_c;
  logic             is_store;
  logic             misaligned;
  logic             reject;

  mips_cpu_store_align u_align (
    .opcode     (bus.req_opcode),
    .offset     (bus.req_addr[1:0]),
    .rt         (bus.req_data),
    .byteenable (be_c),
    .writedata  (data_c),
    .is_store   (is_store),
    .misaligned (misaligned)
  );

`ifdef MIPS_STORE_ALIGN_CHECK_EN
  assign reject = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign reject = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    write_nxt    = 1'b0;
    addr_nxt     = addr_q;
    be_nxt       = be_q;
    data_nxt     = data_q;
    done_nxt     = 1'b0;
    bus_err_nxt  = 1'b0;
    addr_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!is_store) begin
            // Non-store opcodes complete immediately without touching the bus.
            done_nxt = 1'b1;
          end else if (reject) begin
            done_nxt     = 1'b1;
            addr_err_nxt = 1'b1;
          end else begin
            state_nxt = WRITE;
            write_nxt = 1'b1;
            cnt_nxt   = '0;
            addr_nxt  = {bus.req_addr[31:2], 2'b00};
            be_nxt    = be_c;
            data_nxt  = data_c;
          end
        end
      end
      WRITE: begin
        write_nxt = 1'b1;
        if (!bus.waitrequest) begin
          state_nxt = IDLE;
          write_nxt = 1'b0;
          done_nxt  = 1'b1;
        end else if (WAIT_LIMIT > 0) begin
          if (cnt == CNT_LAST) begin
            state_nxt   = IDLE;
            write_nxt   = 1'b0;
            done_nxt    = 1'b1;
            bus_err_nxt = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      write_q    <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'b0000;
      data_q     <= 32'h0;
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      write_q    <= write_nxt;
      addr_q     <= addr_nxt;
      be_q       <= be_nxt;
      data_q     <= data_nxt;
      done_q     <= done_nxt;
      bus_err_q  <= bus_err_nxt;
      addr_err_q <= addr_err_nxt;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.write      = write_q;
  assign bus.address    = addr_q;
  assign bus.byteenable = be_q;
  assign bus.writedata  = data_q;
  assign bus.done       = done_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_mips_cpu_store_unit.sv
// Bench for mips_cpu_store_unit (WAIT_LIMIT=4): lane-level reference model plus directed literals.
// Inputs change 1 time unit after posedge; the model compare runs on every negedge.
// Honours MIPS_STORE_ALIGN_CHECK_EN for the misaligned-sw case.
module tb_mips_cpu_store_unit;

  localparam int WL = 4;
  localparam logic [5:0] T_SB  = 6'b101000;
  localparam logic [5:0] T_SH  = 6'b101001;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_SWL = 6'b101010;
  localparam logic [5:0] T_SWR = 6'b101110;
  localparam logic [5:0] T_LW  = 6'b100011;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_store_unit_if sif ();

  mips_cpu_store_unit #(.WAIT_LIMIT(WL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Lane-by-lane view of a store: which byte of rt each lane carries.
  function automatic void lanes(input logic [5:0] op, input logic [1:0] k, input logic [31:0] rt,
                                output logic [3:0] be, output logic [31:0] d);
    int b;
    bit en;
    bit zero;
    be = 4'b0000;
    d  = 32'h0;
    for (int j = 0; j < 4; j++) begin
      en = 1'b0; zero = 1'b0; b = 0;
      case (op)
        T_SB:  begin en = (j == int'(k));     b = 0; end
        T_SH:  begin en = ((j / 2) == int'(k[1])); b = j % 2; end
        T_SW:  begin en = 1'b1;               b = j; end
        T_SWL: begin en = (j <= int'(k)); zero = !en; b = en ? j + 3 - int'(k) : 0; end
        T_SWR: begin en = (j >= int'(k)); zero = !en; b = en ? j - int'(k) : 0; end
        default: ;
      endcase
      be[j] = en;
      d[8*j +: 8] = zero ? 8'h00 : rt[8*b +: 8];
    end
  endfunction

  function automatic bit is_st(input logic [5:0] op);
    return op == T_SB || op == T_SH || op == T_SW || op == T_SWL || op == T_SWR;
  endfunction

  function automatic bit bad_align(input logic [5:0] op, input logic [1:0] k);
`ifdef MIPS_STORE_ALIGN_CHECK_EN
    return (op == T_SH && k[0]) || (op == T_SW && k != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: expected bus/handshake state after each edge.
  bit          m_busy = 0;
  int          m_stalls = 0;
  bit          m_done = 0, m_berr = 0, m_aerr = 0;
  logic [31:0] m_addr = 0, m_data = 0;
  logic [3:0]  m_be = 0;

  always @(posedge clk or negedge reset_n) begin
    logic [3:0]  be;
    logic [31:0] d;
    if (!reset_n) begin
      m_busy <= 0; m_stalls <= 0; m_done <= 0; m_berr <= 0; m_aerr <= 0;
    end else begin
      m_done <= 0; m_berr <= 0; m_aerr <= 0;
      if (m_busy) begin
        if (!sif.waitrequest) begin
          m_busy <= 0; m_done <= 1;
        end else if (m_stalls + 1 == WL) begin
          m_busy <= 0; m_done <= 1; m_berr <= 1;
        end else begin
          m_stalls <= m_stalls + 1;
        end
      end else if (sif.req_valid) begin
        if (!is_st(sif.req_opcode)) begin
          m_done <= 1;
        end else if (bad_align(sif.req_opcode, sif.req_addr[1:0])) begin
          m_done <= 1; m_aerr <= 1;
        end else begin
          lanes(sif.req_opcode, sif.req_addr[1:0], sif.req_data, be, d);
          m_busy <= 1; m_stalls <= 0;
          m_addr <= sif.req_addr & 32'hFFFF_FFFC;
          m_be <= be; m_data <= d;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("m.write", 32'(sif.write), 32'(m_busy));
      chk("m.ready", 32'(sif.req_ready), 32'(!m_busy));
      chk("m.done", 32'(sif.done), 32'(m_done));
      chk("m.bus_err", 32'(sif.bus_err), 32'(m_berr));
      chk("m.addr_err", 32'(sif.addr_err), 32'(m_aerr));
      if (m_busy) begin
        chk("m.address", sif.address, m_addr);
        chk("m.be", 32'(sif.byteenable), 32'(m_be));
        chk("m.data", sif.writedata, m_data);
      end
    end
  end

  task automatic store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input int stalls, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ed, input string nm);
    sif.req_valid = 1'b1; sif.req_opcode = op; sif.req_addr = a; sif.req_data = rt;
    sif.waitrequest = 1'b0;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    for (int s = 0; s <= stalls; s++) begin
      sif.waitrequest = (s < stalls);
      chk({nm, ".write"}, 32'(sif.write), 32'd1);
      chk({nm, ".ready"}, 32'(sif.req_ready), 32'd0);
      chk({nm, ".address"}, sif.address, ea);
      chk({nm, ".be"}, 32'(sif.byteenable), 32'(ebe));
      chk({nm, ".data"}, sif.writedata, ed);
      @(posedge clk); #1;
    end
    sif.waitrequest = 1'b0;
    chk({nm, ".done"}, 32'(sif.done), 32'd1);
    chk({nm, ".write_off"}, 32'(sif.write), 32'd0);
    chk({nm, ".bus_err"}, 32'(sif.bus_err), 32'd0);
  endtask

  initial begin
    int cycles;
    sif.req_valid = 1'b0; sif.req_opcode = 6'h0; sif.req_addr = 32'h0;
    sif.req_data = 32'h0; sif.waitrequest = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst.write", 32'(sif.write), 32'd0);
    chk("rst.done", 32'(sif.done), 32'd0);
    chk("rst.ready", 32'(sif.req_ready), 32'd1);
    chk("rst.address", sif.address, 32'h0);
    chk("rst.be", 32'(sif.byteenable), 32'h0);
    chk("rst.data", sif.writedata, 32'h0);
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    store(T_SB,  32'h0000_1002, 32'hAABB_CCDD, 0, 32'h0000_1000, 4'b0100, 32'hDDDD_DDDD, "sb");
    store(T_SH,  32'h0000_2002, 32'hAABB_CCDD, 0, 32'h0000_2000, 4'b1100, 32'hCCDD_CCDD, "sh");
    store(T_SWL, 32'h0000_3001, 32'hAABB_CCDD, 0, 32'h0000_3000, 4'b0011, 32'h0000_AABB, "swl1");
    store(T_SWR, 32'h0000_3001, 32'hAABB_CCDD, 0, 32'h0000_3000, 4'b1110, 32'hBBCC_DD00, "swr1");
    store(T_SW,  32'h0000_4000, 32'h1234_5678, 3, 32'h0000_4000, 4'b1111, 32'h1234_5678, "sw_stall");
    store(T_SB,  32'h0000_5003, 32'h0102_0304, 0, 32'h0000_5000, 4'b1000, 32'h0404_0404, "sb3");
    store(T_SH,  32'h0000_6000, 32'h0000_5566, 1, 32'h0000_6000, 4'b0011, 32'h5566_5566, "sh0");
    store(T_SWL, 32'h0000_7000, 32'hAABB_CCDD, 0, 32'h0000_7000, 4'b0001, 32'h0000_00AA, "swl0");
    store(T_SWL, 32'h0000_7003, 32'hAABB_CCDD, 0, 32'h0000_7000, 4'b1111, 32'hAABB_CCDD, "swl3");
    store(T_SWR, 32'h0000_8003, 32'hAABB_CCDD, 0, 32'h0000_8000, 4'b1000, 32'hDD00_0000, "swr3");

    // Non-store opcode: no bus write, done next cycle.
    sif.req_valid = 1'b1; sif.req_opcode = T_LW; sif.req_addr = 32'h0000_9000;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    chk("lw.done", 32'(sif.done), 32'd1);
    chk("lw.write", 32'(sif.write), 32'd0);
    chk("lw.ready", 32'(sif.req_ready), 32'd1);

    // Timeout: waitrequest stuck high.
    sif.req_valid = 1'b1; sif.req_opcode = T_SW; sif.req_addr = 32'h0000_A000;
    sif.req_data = 32'hCAFE_F00D; sif.waitrequest = 1'b1;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    cycles = 0;
    while (sif.write === 1'b1 && cycles < 20) begin
      cycles++;
      @(posedge clk); #1;
    end
    chk("to.cycles", 32'(cycles), 32'd4);
    chk("to.done", 32'(sif.done), 32'd1);
    chk("to.bus_err", 32'(sif.bus_err), 32'd1);
    sif.waitrequest = 1'b0;
    store(T_SB, 32'h0000_B001, 32'h0000_0077, 0, 32'h0000_B000, 4'b0010, 32'h7777_7777, "after_to");

    // Misaligned sw.
`ifdef MIPS_STORE_ALIGN_CHECK_EN
    sif.req_valid = 1'b1; sif.req_opcode = T_SW; sif.req_addr = 32'h0000_4002;
    sif.req_data = 32'h1122_3344;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    chk("mis.write", 32'(sif.write), 32'd0);
    chk("mis.done", 32'(sif.done), 32'd1);
    chk("mis.addr_err", 32'(sif.addr_err), 32'd1);
`else
    store(T_SW, 32'h0000_4002, 32'h1122_3344, 0, 32'h0000_4000, 4'b1111, 32'h1122_3344, "mis");
`endif

    // Reset in the middle of a stalled write.
    sif.req_valid = 1'b1; sif.req_opcode = T_SW; sif.req_addr = 32'h0000_C000;
    sif.req_data = 32'h5A5A_5A5A; sif.waitrequest = 1'b1;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    chk("rw.write_before", 32'(sif.write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw.write", 32'(sif.write), 32'd0);
    chk("rw.address", sif.address, 32'h0);
    chk("rw.be", 32'(sif.byteenable), 32'h0);
    @(posedge clk); #1;
    chk("rw.done", 32'(sif.done), 32'd0);
    sif.waitrequest = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rw.idle_done", 32'(sif.done), 32'd0);
    chk("rw.ready", 32'(sif.req_ready), 32'd1);
    store(T_SWR, 32'h0000_D002, 32'h1122_3344, 0, 32'h0000_D000, 4'b1100, 32'h3344_0000, "after_rst");

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
